// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared types and constants for the core memory-port arbiter.
package ysyx_23060180_mem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060180_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester not granted last wins.
module ysyx_23060180_rr_arb2
  import ysyx_23060180_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[REQ_IFU] && req[REQ_LSU]) begin
        if (rr_last == REQ_LSU) gnt[REQ_IFU] = 1'b1;
        else                    gnt[REQ_LSU] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rr_last <= REQ_LSU;
    else if (gnt[REQ_IFU]) rr_last <= REQ_IFU;
    else if (gnt[REQ_LSU]) rr_last <= REQ_LSU;
  end

endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// Shares one memory port between IFU reads and LSU reads/writes, with at most
// one read in flight and fixed-latency read data routed back to its owner.
module ysyx_23060180_mem_arbiter
  import ysyx_23060180_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_wdone,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        gnt;
  logic              rd_grant;
  logic              resp;

  // Arbitration is frozen while reset is held so nothing reaches memory.
  ysyx_23060180_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state == IDLE) && !rst),
    .req ({lsu_req, ifu_req}),
    .gnt (gnt)
  );

  assign ifu_gnt  = gnt[REQ_IFU];
  assign lsu_gnt  = gnt[REQ_LSU];
  assign rd_grant = ifu_gnt || (lsu_gnt && !lsu_we);
  assign resp     = (state == RD_WAIT) && (cnt == LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_grant) state_next = RD_WAIT;
      RD_WAIT: if (resp)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      owner     <= REQ_IFU;
      rdata_q   <= '0;
      lsu_wdone <= 1'b0;
    end else begin
      lsu_wdone <= mem_wr;
      if (rd_grant) begin
        cnt   <= CNT_W'(1);
        owner <= ifu_gnt ? REQ_IFU : REQ_LSU;
      end else if (state == RD_WAIT && !resp) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (resp) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    if (ifu_gnt) begin
      mem_rd   = 1'b1;
      mem_addr = ifu_addr;
    end else if (lsu_gnt) begin
      mem_rd    = !lsu_we;
      mem_wr    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
      mem_wmask = lsu_wmask;
    end
    ifu_rvalid = resp && (owner == REQ_IFU);
    lsu_rvalid = resp && (owner == REQ_LSU);
    ifu_rdata  = ifu_rvalid ? mem_rdata : rdata_q;
    lsu_rdata  = lsu_rvalid ? mem_rdata : rdata_q;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// Directed bench: instance a runs RD_LAT=1, instance b RD_LAT=3, shared stimulus.
module tb_ysyx_23060180_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, lsu_req, lsu_we;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;

  logic        a_ifu_gnt, a_ifu_rvalid, a_lsu_gnt, a_lsu_rvalid, a_lsu_wdone;
  logic        a_mem_rd, a_mem_wr, a_busy;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wmask;
  logic        b_ifu_gnt, b_ifu_rvalid, b_lsu_gnt, b_lsu_rvalid, b_lsu_wdone;
  logic        b_mem_rd, b_mem_wr, b_busy;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(a_ifu_gnt),
    .ifu_rvalid(a_ifu_rvalid), .ifu_rdata(a_ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(a_lsu_gnt),
    .lsu_rvalid(a_lsu_rvalid), .lsu_rdata(a_lsu_rdata), .lsu_wdone(a_lsu_wdone),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(mem_rdata),
    .busy(a_busy)
  );

  ysyx_23060180_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(b_ifu_gnt),
    .ifu_rvalid(b_ifu_rvalid), .ifu_rdata(b_ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(b_lsu_gnt),
    .lsu_rvalid(b_lsu_rvalid), .lsu_rdata(b_lsu_rdata), .lsu_wdone(b_lsu_wdone),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(mem_rdata),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each cycle: inputs change 1ns after the rising edge, checks happen 4ns after.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req = 0; lsu_req = 0; lsu_we = 0;
    ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; mem_rdata = 0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    settle();
    check("rst_a_busy",  32'(a_busy), 0);
    check("rst_b_busy",  32'(b_busy), 0);
    check("rst_a_gnt",   32'({a_ifu_gnt, a_lsu_gnt}), 0);
    check("rst_a_strb",  32'({a_mem_rd, a_mem_wr, a_lsu_wdone}), 0);
    check("rst_a_rdata", a_ifu_rdata, 0);

    // 1: single IFU read, RD_LAT=1
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    settle();
    check("t1_gnt", 32'(a_ifu_gnt), 1);
    check("t1_mem_rd", 32'(a_mem_rd), 1);
    check("t1_addr", a_mem_addr, 32'h8000_0000);
    check("t1_lsu_rv_T", 32'(a_lsu_rvalid), 0);
    next_cyc();
    ifu_req = 0; mem_rdata = 32'h0010_0073;
    settle();
    check("t1_rvalid", 32'(a_ifu_rvalid), 1);
    check("t1_rdata", a_ifu_rdata, 32'h0010_0073);
    check("t1_lsu_rv", 32'(a_lsu_rvalid), 0);
    next_cyc();
    mem_rdata = 32'h0;
    settle();
    check("t1_rv_off", 32'(a_ifu_rvalid), 0);
    check("t1_hold", a_ifu_rdata, 32'h0010_0073);

    // 2: both read requesters held high, strict alternation IFU/LSU/IFU
    do_reset();
    ifu_req = 1; ifu_addr = 32'h200; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      logic       exp_ifu;
      logic [31:0] d;
      exp_ifu = (k % 2 == 0);
      d = 32'h1000 + 32'(k);
      settle();
      $display("t2 grant %0d ifu_gnt=%0d lsu_gnt=%0d addr=%h", k, a_ifu_gnt, a_lsu_gnt, a_mem_addr);
      check("t2_ifu_gnt", 32'(a_ifu_gnt), 32'(exp_ifu));
      check("t2_lsu_gnt", 32'(a_lsu_gnt), 32'(!exp_ifu));
      check("t2_addr", a_mem_addr, exp_ifu ? 32'h200 : 32'h100);
      next_cyc();
      mem_rdata = d;
      settle();
      check("t2_gnt_busy", 32'({a_ifu_gnt, a_lsu_gnt}), 0);
      check("t2_ifu_rv", 32'(a_ifu_rvalid), 32'(exp_ifu));
      check("t2_lsu_rv", 32'(a_lsu_rvalid), 32'(!exp_ifu));
      check("t2_rdata", exp_ifu ? a_ifu_rdata : a_lsu_rdata, d);
      next_cyc();
    end

    // 3: LSU write, back-to-back IFU read grant at T+1, then a wmask=0 write
    do_reset();
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    settle();
    check("t3_lsu_gnt", 32'(a_lsu_gnt), 1);
    check("t3_strobes", 32'({a_mem_wr, a_mem_rd}), 32'b10);
    check("t3_addr", a_mem_addr, 32'h8000_1000);
    check("t3_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    check("t3_wmask", 32'(a_mem_wmask), 32'hF);
    check("t3_busy", 32'(a_busy), 0);
    next_cyc();
    lsu_req = 0; ifu_req = 1; ifu_addr = 32'h8000_0004;
    settle();
    check("t3_wdone", 32'(a_lsu_wdone), 1);
    check("t3_ifu_gnt", 32'(a_ifu_gnt), 1);
    check("t3_strobes2", 32'({a_mem_wr, a_mem_rd}), 32'b01);
    next_cyc();
    ifu_req = 0; mem_rdata = 32'h1234_5678;
    settle();
    check("t3_wdone_off", 32'(a_lsu_wdone), 0);
    check("t3_ifu_rv", 32'(a_ifu_rvalid), 1);
    next_cyc();
    lsu_req = 1; lsu_we = 1; lsu_wmask = 4'h0; lsu_addr = 32'h8000_1003;
    settle();
    check("t3_m0_wr", 32'(a_mem_wr), 1);
    check("t3_m0_mask", 32'(a_mem_wmask), 0);
    check("t3_m0_addr", a_mem_addr, 32'h8000_1003);
    next_cyc();
    lsu_req = 0;
    settle();
    check("t3_m0_wdone", 32'(a_lsu_wdone), 1);

    // 4: RD_LAT=3, IFU read with req held
    do_reset();
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    settle();
    check("t4_gnt", 32'(b_ifu_gnt), 1);
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      if (c == 3) mem_rdata = 32'h0000_ABCD;
      settle();
      check("t4_busy", 32'(b_busy), 1);
      check("t4_gnt_off", 32'(b_ifu_gnt), 0);
      check("t4_rvalid", 32'(b_ifu_rvalid), 32'(c == 3));
    end
    check("t4_rdata", b_ifu_rdata, 32'h0000_ABCD);
    next_cyc();
    settle();
    check("t4_regnt", 32'(b_ifu_gnt), 1);
    check("t4_idle", 32'(b_busy), 0);

    // 5: RD_LAT=3, reset during the read; IFU wins first after release
    do_reset();
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    settle();
    check("t5_gnt", 32'(b_ifu_gnt), 1);
    next_cyc();
    rst = 1;
    settle();
    check("t5_busy_rst", 32'(b_busy), 0);
    check("t5_rv_rst", 32'(b_ifu_rvalid), 0);
    next_cyc();
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h300;
    next_cyc();
    rst = 0; mem_rdata = 32'h5555_AAAA;
    settle();
    check("t5_rv_T3", 32'({b_ifu_rvalid, b_lsu_rvalid}), 0);
    check("t5_first_ifu", 32'(b_ifu_gnt), 1);
    check("t5_first_lsu", 32'(b_lsu_gnt), 0);

    // 6: RD_LAT=3, LSU read asked for during an IFU read and withdrawn
    do_reset();
    ifu_req = 1; ifu_addr = 32'h8000_0010;
    settle();
    check("t6_ifu_gnt", 32'(b_ifu_gnt), 1);
    next_cyc();
    ifu_req = 0; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h400;
    settle();
    check("t6_no_gnt1", 32'({b_lsu_gnt, b_mem_rd}), 0);
    next_cyc();
    lsu_req = 0;
    settle();
    check("t6_no_gnt2", 32'({b_lsu_gnt, b_mem_rd}), 0);
    next_cyc();
    mem_rdata = 32'h6666_0000;
    settle();
    check("t6_ifu_rv", 32'(b_ifu_rvalid), 1);
    check("t6_lsu_rv", 32'(b_lsu_rvalid), 0);
    next_cyc();
    settle();
    check("t6_after", 32'({b_lsu_gnt, b_mem_rd, b_lsu_rvalid}), 0);
    check("t6_idle", 32'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060180_mem_arbiter.md
Name: ysyx_23060180_mem_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). It performs 2-way round-robin arbitration and allows only one outstanding read at a time. It tracks fixed read latency and routes read data back to the owning requester. It sits between the CPU core stages and the memory model, and replaces the core's direct mem_rd/mem_raddr drive.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (mask width = DATA_W/8)
RD_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ifu_req  in  1  IFU read request; hold with addr until ifu_gnt
ifu_addr  in  ADDR_W  IFU read address
ifu_gnt  out  1  IFU request accepted this cycle
ifu_rvalid  out  1  ifu_rdata valid (1-cycle pulse)
ifu_rdata  out  DATA_W  IFU read data
lsu_req  in  1  LSU request; hold with all fields until lsu_gnt
lsu_we  in  1  1 = write, 0 = read
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte write enables
lsu_gnt  out  1  LSU request accepted this cycle
lsu_rvalid  out  1  lsu_rdata valid (1-cycle pulse)
lsu_rdata  out  DATA_W  LSU read data
lsu_wdone  out  1  write completed (1-cycle pulse)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte mask
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd
busy  out  1  read outstanding (state != IDLE)

Behaviour:
- Reset values (async on rst): state=IDLE, rr_last=LSU (IFU wins the first tie), cnt=0, owner=IFU, rdata_q=0. All gnt/rvalid/wdone/mem_rd/mem_wr/busy outputs are 0.
- FSM has two states, IDLE and RD_WAIT. Grants are issued only in IDLE.
- Grant is combinational in IDLE:
  - Only one req high -> grant it.
  - Both high -> grant the one not equal to rr_last.
  - rr_last updates on every grant.
- Grant cycle T:
  - mem_addr, mem_wdata and mem_wmask are muxed combinationally from the granted requester.
  - mem_rd = granted read; mem_wr = granted LSU write.
  - Outside grant cycles, mem_rd=mem_wr=0 and mem_addr/mem_wdata/mem_wmask are don't-care (drive 0).
- Read grant:
  - owner <= requester, cnt <= 1, state <= RD_WAIT.
  - In RD_WAIT, when cnt == RD_LAT (cycle T+RD_LAT): owner's rvalid=1 and rdata=mem_rdata (combinational); rdata_q captures it; state <= IDLE.
  - Otherwise cnt increments.
  - The earliest next grant is at T+RD_LAT+1.
- Write grant: state stays IDLE. lsu_wdone=1 at T+1 (registered). A new grant may occur at T+1 (back-to-back).
- Outside the response cycle, ifu_rdata/lsu_rdata hold rdata_q (last read value). Only the owner sees rvalid.
- Requester drops req before gnt: nothing is issued and no response is produced. The requester may drop req in the cycle after gnt.
- No alignment check. Address and mask pass through unchanged. A write with wmask=0 still issues mem_wr.
- Reset mid-read: returns to IDLE immediately and no rvalid is produced for the lost read. mem_rdata arriving after reset release is ignored.

Decomposition:
- Package ysyx_23060180_mem_pkg holds:
  - state enum {IDLE, RD_WAIT}
  - requester id localparams REQ_IFU=0, REQ_LSU=1
  - RESET_PC 32'h80000000 (shared with the core)
- One sub-module: ysyx_23060180_rr_arb2. It is a 2-way round-robin picker with an enable input, and holds the rr_last register internally.

Test Plan:
1. RD_LAT=1, IFU read 0x80000000. Expect at T: ifu_gnt=1, mem_rd=1, mem_addr=0x80000000. Drive mem_rdata=0x00100073 at T+1 and expect ifu_rvalid=1, ifu_rdata=0x00100073 at T+1, with lsu_rvalid=0 throughout.
2. After reset, hold ifu_req and lsu_req high continuously as reads at RD_LAT=1. Expect grants IFU@T, LSU@T+2, IFU@T+4 (strict alternation), each rvalid only to its owner.
3. LSU write to 0x80001000 with wdata=0xDEADBEEF and wmask=0xF. Expect mem_wr=1 at T and lsu_wdone=1 at T+1. A pending IFU read is granted at T+1.
4. RD_LAT=3, IFU read with ifu_req held high. Expect gnt at T, busy=1 over T+1..T+3, ifu_rvalid at T+3, next ifu_gnt at T+4.
5. RD_LAT=3: assert rst at T+1 of an IFU read. Expect busy=0 immediately and no rvalid at T+3. After release with both req high, IFU is granted first.
6. LSU read requested while an IFU read is outstanding, then dropped before IDLE. Expect no lsu_gnt, no mem_rd for it, and no lsu_rvalid.
